// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: 2-flop synchroniser, shared-tick debouncer and change strobe.
// Define SW_DEBOUNCE_EVENT_EN to add sticky per-bit change flags and an interrupt output.
module sw_debounce_sync #(
  parameter int WIDTH        = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 5
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic             sw_changed,
  output logic             sw_valid
`ifdef SW_DEBOUNCE_EVENT_EN
  ,
  input  logic [WIDTH-1:0] sw_event_clr,
  output logic [WIDTH-1:0] sw_event,
  output logic             sw_irq
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             init_cnt;
  logic [CW-1:0]             init_cnt_next;
  logic [WIDTH-1:0]          sync_meta;
  logic [WIDTH-1:0]          sync;
  logic [PW-1:0]             pre_cnt;
  logic                      tick;
  logic [WIDTH-1:0][CW-1:0]  cnt;
  logic [WIDTH-1:0][CW-1:0]  cnt_next;
  logic [WIDTH-1:0]          deb_next;
  logic [WIDTH-1:0]          adopt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
    end
  end

  // Tick is the wrap condition itself, so the first tick lands on cycle TICK_DIV.
  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_comb begin
    cnt_next = cnt;
    deb_next = sw_debounced;
    adopt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync[i] == sw_debounced[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_MAX) begin
          deb_next[i] = sync[i];
          cnt_next[i] = '0;
          adopt[i]    = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt          <= '0;
      sw_debounced <= '0;
    end else begin
      cnt          <= cnt_next;
      sw_debounced <= deb_next;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // INIT lasts exactly STABLE_TICKS ticks, long enough for the power-up level to be adopted silently.
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    case (state)
      ST_INIT: begin
        if (tick) begin
          if (init_cnt == CNT_MAX) begin
            state_next    = ST_RUN;
            init_cnt_next = '0;
          end else begin
            init_cnt_next = init_cnt + CW'(1);
          end
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_changed <= 1'b0;
      sw_valid   <= 1'b0;
    end else begin
      sw_changed <= (state == ST_RUN) && (|adopt);
      sw_valid   <= (state_next == ST_RUN);
    end
  end

`ifdef SW_DEBOUNCE_EVENT_EN
  // A same-cycle adoption overrides the clear so no change is ever lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_event <= '0;
      sw_irq   <= 1'b0;
    end else begin
      sw_event <= (sw_event & ~sw_event_clr) | (adopt & {WIDTH{state == ST_RUN}});
      sw_irq   <= |sw_event;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Scoreboard bench for sw_debounce_sync with TICK_DIV=4, STABLE_TICKS=3 (12-cycle debounce).
// Define SW_DEBOUNCE_EVENT_EN to also exercise the sticky event flags.
module tb_sw_debounce_sync;

  localparam int WIDTH = 10;

  logic             clk_clk;
  logic             reset_reset_n;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_debounced;
  logic             sw_changed;
  logic             sw_valid;
`ifdef SW_DEBOUNCE_EVENT_EN
  logic [WIDTH-1:0] sw_event_clr;
  logic [WIDTH-1:0] sw_event;
  logic             sw_irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  sw_debounce_sync #(
    .WIDTH        (WIDTH),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sw_raw        (sw_raw),
    .sw_debounced  (sw_debounced),
    .sw_changed    (sw_changed),
    .sw_valid      (sw_valid)
`ifdef SW_DEBOUNCE_EVENT_EN
    ,
    .sw_event_clr  (sw_event_clr),
    .sw_event      (sw_event),
    .sw_irq        (sw_irq)
`endif
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected debounced value is queued before the raw input moves.
  task automatic applyStimulus(input logic [WIDTH-1:0] raw, input bit expect_change, input logic [WIDTH-1:0] exp_val);
    if (expect_change) exp_q.push_back(exp_val);
    sw_raw = raw;
  endtask

  task automatic wait_debounced(input logic [WIDTH-1:0] target, input int bound, input string name);
    int n = 0;
    while (sw_debounced !== target && n < bound) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput(name, {22'd0, sw_debounced}, {22'd0, target});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Monitor: every change pulse must match the next queued value.
  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1 && sw_changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_sw_changed: actual sw_debounced=%0h required no pulse at %0t", sw_debounced, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        checkOutput("changed_value", {22'd0, sw_debounced}, {22'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_reset_n = 1'b0;
    sw_raw        = 10'h3FF;
`ifdef SW_DEBOUNCE_EVENT_EN
    sw_event_clr  = '0;
`endif
    idle(3);
    checkOutput("reset_debounced", {22'd0, sw_debounced}, 32'h0);
    checkOutput("reset_changed", {31'd0, sw_changed}, 32'h0);
    checkOutput("reset_valid", {31'd0, sw_valid}, 32'h0);

    // Power-up: level adopted silently at cycle 12
    reset_reset_n = 1'b1;
    idle(11);
    checkOutput("init_valid_c11", {31'd0, sw_valid}, 32'h0);
    checkOutput("init_deb_c11", {22'd0, sw_debounced}, 32'h0);
    idle(1);
    checkOutput("init_valid_c12", {31'd0, sw_valid}, 32'h1);
    checkOutput("init_deb_c12", {22'd0, sw_debounced}, 32'h3FF);
    idle(2);

    // Clean steps
    applyStimulus(10'h000, 1'b1, 10'h000);
    wait_debounced(10'h000, 14, "step_to_000");
    idle(3);
    applyStimulus(10'h001, 1'b1, 10'h001);
    wait_debounced(10'h001, 14, "step_to_001");
    idle(3);

    // Bounce on bit 3
    for (int p = 0; p < 12; p++) begin
      applyStimulus((p % 2 == 0) ? 10'h009 : 10'h001, 1'b0, 10'h000);
      idle(5);
    end
    checkOutput("bounce_hold", {22'd0, sw_debounced}, 32'h001);
    applyStimulus(10'h009, 1'b1, 10'h009);
    wait_debounced(10'h009, 14, "bounce_settle");
    idle(3);

    // Simultaneous updates
    applyStimulus(10'h000, 1'b1, 10'h000);
    wait_debounced(10'h000, 14, "dual_fall");
    idle(3);
    applyStimulus(10'h201, 1'b1, 10'h201);
    wait_debounced(10'h201, 14, "dual_rise");
    idle(3);

    // Reset in the middle of a bit-5 count
    applyStimulus(10'h221, 1'b0, 10'h000);
    idle(10);
    reset_reset_n = 1'b0;
    #1;
    checkOutput("midreset_deb", {22'd0, sw_debounced}, 32'h0);
    checkOutput("midreset_changed", {31'd0, sw_changed}, 32'h0);
    checkOutput("midreset_valid", {31'd0, sw_valid}, 32'h0);
`ifdef SW_DEBOUNCE_EVENT_EN
    checkOutput("midreset_event", {22'd0, sw_event}, 32'h0);
    checkOutput("midreset_irq", {31'd0, sw_irq}, 32'h0);
`endif
    idle(2);
    reset_reset_n = 1'b1;
    idle(11);
    checkOutput("reinit_valid_c11", {31'd0, sw_valid}, 32'h0);
    idle(1);
    checkOutput("reinit_valid_c12", {31'd0, sw_valid}, 32'h1);
    checkOutput("reinit_deb_c12", {22'd0, sw_debounced}, 32'h221);
    idle(2);

`ifdef SW_DEBOUNCE_EVENT_EN
    checkOutput("init_no_event", {22'd0, sw_event}, 32'h0);
    checkOutput("init_no_irq", {31'd0, sw_irq}, 32'h0);
    sw_event_clr = 10'h004;
    applyStimulus(10'h225, 1'b1, 10'h225);
    wait_debounced(10'h225, 14, "event_adopt");
    checkOutput("event_set_wins", {22'd0, sw_event}, 32'h004);
    checkOutput("irq_lags", {31'd0, sw_irq}, 32'h0);
    sw_event_clr = 10'h000;
    idle(1);
    checkOutput("irq_set", {31'd0, sw_irq}, 32'h1);
    checkOutput("event_held", {22'd0, sw_event}, 32'h004);
    sw_event_clr = 10'h004;
    idle(1);
    sw_event_clr = 10'h000;
    checkOutput("event_cleared", {22'd0, sw_event}, 32'h0);
    idle(1);
    checkOutput("irq_cleared", {31'd0, sw_irq}, 32'h0);
    idle(2);
`endif

    checkOutput("pending_expect", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
